imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_SIZE, default 132, meaning instruction-memory depth in bytes (addresses 0..IMEM_SIZE-1).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning idle cycles allowed between accepted bytes before abort.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  in  1  single-cycle request to begin a load.
REQ-006 SHALL have port in_valid  in  1  byte-stream source has a byte.
REQ-007 SHALL have port in_data  in  8  byte-stream payload.
REQ-008 SHALL have port in_ready  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en  out  1  instruction-memory byte write strobe.
REQ-010 SHALL have port wr_addr  out  8  instruction-memory byte address.
REQ-011 SHALL have port wr_data  out  8  instruction-memory write byte.
REQ-012 SHALL have port cpu_hold  out  1  processor must not fetch (PC held at 0).
REQ-013 SHALL have port done  out  1  image loaded and checksum correct.
REQ-014 SHALL have port error  out  1  load aborted.
REQ-015 SHALL have port err_code  out  2  01 length>IMEM_SIZE, 10 checksum mismatch, 11 timeout, 00 none.
REQ-016 SHALL have port byte_count  out  8  payload bytes written so far.

Function
REQ-017 SHALL transfer a byte only on a rising edge where in_valid and in_ready are both 1.
REQ-018 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR; in_ready=1 only in LEN_LO, LEN_HI, DATA, CSUM.
REQ-019 SHALL move IDLE/DONE/ERR -> LEN_LO on start=1; start in any other state SHALL be ignored.
REQ-020 SHALL take stream format: length low byte, length high byte (16-bit little-endian), length payload bytes, one checksum byte.
REQ-021 SHALL go LEN_HI -> ERR with err_code 01 when length > IMEM_SIZE, -> CSUM when length = 0, else -> DATA.
REQ-022 SHALL write the k-th payload byte (k from 0) to wr_addr=k with wr_en=1 exactly one cycle after its acceptance; wr_en=0 otherwise.
REQ-023 SHALL increment byte_count per accepted payload byte and move DATA -> CSUM after the byte with count = length.
REQ-024 SHALL compute checksum as XOR of both length bytes and all payload bytes; CSUM -> DONE on match, -> ERR with err_code 10 on mismatch.
REQ-025 SHALL count consecutive cycles with in_ready=1 and no transfer; on reaching TIMEOUT SHALL go to ERR with err_code 11; counter clears on every transfer and on state entry.
REQ-026 SHALL drive cpu_hold=1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-027 SHALL clear byte_count, checksum accumulator, err_code and timeout counter on entry to LEN_LO.
REQ-028 SHALL keep err_code and byte_count stable while in ERR or DONE.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, err_code=00, byte_count=0.
REQ-030 SHALL, on reset mid-load, abandon the load with no further writes; a new start is required.

Structure
REQ-031 SHALL place IMEM_SIZE default, state enumeration and err_code constants in shared package imem_pkg.
REQ-032 SHALL implement the idle timeout as sub-module loader_timeout (clear, tick, expired).

Verification
REQ-033 Bench SHALL check: start, stream 04 00 30 F2 0A 00 csum=CC -> writes 30,F2,0A,00 to addr 0..3, done=1, cpu_hold=0, byte_count=4.
REQ-034 Bench SHALL check: length 0x0085 (133) -> error=1, err_code=01, no wr_en pulse.
REQ-035 Bench SHALL check: valid 4-byte image with checksum byte 00 -> error=1, err_code=10, byte_count=4, cpu_hold=1.
REQ-036 Bench SHALL check: in_valid held low 255 cycles after two payload bytes -> error=1, err_code=11; in_valid low 254 cycles -> no error.
REQ-037 Bench SHALL check: rst_n low during DATA after 2 bytes -> all outputs at reset values, next start reloads from addr 0.
REQ-038 Bench SHALL check: 132-byte image with in_valid randomly toggled -> all 132 addresses written once in order, done=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// error codes and the per-state status flags driven on the loader outputs.
package imem_pkg;

    localparam int unsigned IMEM_SIZE_DEF = 132;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned ERR_W         = 2;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_LEN     = 2'b01;
    localparam logic [ERR_W-1:0] ERR_CSUM    = 2'b10;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic cpu_hold;
        logic done;
        logic error;
    } status_t;

    // Status flags that hold for the whole time the FSM sits in state s.
    function automatic status_t status_of(input state_t s);
        status_t st;
        st.in_ready = (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
        st.cpu_hold = (s != DONE);
        st.done     = (s == DONE);
        st.error    = (s == ERR);
        return st;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts consecutive ticks and flags the tick that
// reaches LIMIT so the loader can abort on that same edge.
module loader_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = tick && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and
// writes it into instruction memory while holding the processor.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = IMEM_SIZE_DEF,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [BYTE_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ERR_W-1:0]  err_code,
    output logic [BYTE_W-1:0] byte_count
);

    state_t             state;
    status_t            status;
    logic [BYTE_W-1:0]  len_lo;
    logic [LEN_W-1:0]   len;
    logic [BYTE_W-1:0]  csum;
    logic [LEN_W-1:0]   len_rx;
    logic               xfer;
    logic               start_ok;
    logic               tick;
    logic               expired;

    assign xfer     = in_valid && status.in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign tick     = status.in_ready && !in_valid;
    assign len_rx   = {in_data, len_lo};

    assign in_ready = status.in_ready;
    assign cpu_hold = status.cpu_hold;
    assign done     = status.done;
    assign error    = status.error;

    loader_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (xfer || start_ok),
        .tick    (tick),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            status     <= status_of(IDLE);
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err_code   <= ERR_NONE;
            byte_count <= '0;
            len_lo     <= '0;
            len        <= '0;
            csum       <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_ok) begin
                        state      <= LEN_LO;
                        status     <= status_of(LEN_LO);
                        byte_count <= '0;
                        csum       <= '0;
                        err_code   <= ERR_NONE;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_lo <= in_data;
                        csum   <= csum ^ in_data;
                        state  <= LEN_HI;
                        status <= status_of(LEN_HI);
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len  <= len_rx;
                        csum <= csum ^ in_data;
                        if (len_rx > LEN_W'(IMEM_SIZE)) begin
                            state    <= ERR;
                            status   <= status_of(ERR);
                            err_code <= ERR_LEN;
                        end else if (len_rx == '0) begin
                            state  <= CSUM;
                            status <= status_of(CSUM);
                        end else begin
                            state  <= DATA;
                            status <= status_of(DATA);
                        end
                    end
                end
                DATA: begin
                    // Memory write lands on the cycle after the byte is accepted.
                    if (xfer) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= byte_count;
                        wr_data    <= in_data;
                        byte_count <= byte_count + BYTE_W'(1);
                        csum       <= csum ^ in_data;
                        if (LEN_W'(byte_count) + LEN_W'(1) == len) begin
                            state  <= CSUM;
                            status <= status_of(CSUM);
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state  <= DONE;
                            status <= status_of(DONE);
                        end else begin
                            state    <= ERR;
                            status   <= status_of(ERR);
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    status <= status_of(IDLE);
                end
            endcase

            // Only fires in a receiving state with no transfer, so it never races a byte.
            if (expired) begin
                state    <= ERR;
                status   <= status_of(ERR);
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus sequences
// for idle timeout, mid-load reset and a full-size image with stalls.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] byte_count;

    imem_loader #(
        .IMEM_SIZE (132),
        .TIMEOUT   (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];
    logic [7:0] stream[140];

    typedef struct {
        int         n;
        logic [7:0] b [8];
        logic       exp_done;
        logic       exp_error;
        logic [1:0] exp_code;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns just after the rising edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic run_stream(input int n, input bit gap);
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int i = 0; i < n; i++) send_byte(stream[i], gap);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input int n);
        check({name, "_nwr"}, 32'(log_addr.size()), 32'(n));
        for (int k = 0; k < n && k < log_addr.size(); k++) begin
            check({name, "_addr"}, 32'(log_addr[k]), 32'(k));
            check({name, "_data"}, 32'(log_data[k]), 32'(stream[k + 2]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7, '{8'h04, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'h00, 8'hCC, 8'h00}, 1'b1, 1'b0, 2'b00, 8'd4};
        vecs[1] = '{2, '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'b01, 8'd0};
        vecs[2] = '{7, '{8'h04, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'b10, 8'd4};
        vecs[3] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 2'b00, 8'd0};
        vecs[4] = '{2, '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'b01, 8'd0};
        vecs[5] = '{4, '{8'h01, 8'h00, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 2'b00, 8'd1};
        vecs[6] = '{3, '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'b10, 8'd0};

        // Outputs while held in reset
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Table of complete loads
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 8; i++) stream[i] = vecs[v].b[i];
            run_stream(vecs[v].n, 1'b0);
            check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_error));
            check($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].exp_code));
            check($sformatf("v%0d_byte_count", v), 32'(byte_count), 32'(vecs[v].exp_cnt));
            check($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
            check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd0);
            check_writes($sformatf("v%0d", v), int'(vecs[v].exp_cnt));
        end

        // Idle timeout: 255 silent cycles after two payload bytes aborts
        for (int i = 0; i < 8; i++) stream[i] = vecs[0].b[i];
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
        idle_cycles(255);
        #1;
        check("tmo255_error", 32'(error), 32'd1);
        check("tmo255_err_code", 32'(err_code), 32'd3);
        check("tmo255_cpu_hold", 32'(cpu_hold), 32'd1);
        check("tmo255_byte_count", 32'(byte_count), 32'd2);
        check_writes("tmo255", 2);

        // 254 silent cycles is still within budget
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
        idle_cycles(254);
        #1;
        check("tmo254_error", 32'(error), 32'd0);
        check("tmo254_in_ready", 32'(in_ready), 32'd1);
        for (int i = 4; i < 7; i++) send_byte(stream[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("tmo254_done", 32'(done), 32'd1);
        check_writes("tmo254", 4);

        // Reset in the middle of the payload
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_wr_en", 32'(wr_en), 32'd0);
        check("mrst_wr_addr", 32'(wr_addr), 32'd0);
        check("mrst_wr_data", 32'(wr_data), 32'd0);
        check("mrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        check("mrst_err_code", 32'(err_code), 32'd0);
        check("mrst_byte_count", 32'(byte_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_idle_ready", 32'(in_ready), 32'd0);
        check("mrst_nwr", 32'(log_addr.size()), 32'd2);
        in_valid = 1'b0;
        run_stream(7, 1'b0);
        check("reload_done", 32'(done), 32'd1);
        check("reload_byte_count", 32'(byte_count), 32'd4);
        check_writes("reload", 4);

        // Full-size 132-byte image with random stalls on in_valid
        begin
            logic [7:0] c;
            stream[0] = 8'h84;
            stream[1] = 8'h00;
            for (int k = 0; k < 132; k++) stream[k + 2] = 8'((k * 7 + 3) % 256);
            c = 8'h00;
            for (int i = 0; i < 134; i++) c = c ^ stream[i];
            stream[134] = c;
        end
        run_stream(135, 1'b1);
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_cpu_hold", 32'(cpu_hold), 32'd0);
        check("full_byte_count", 32'(byte_count), 32'd132);
        check_writes("full", 132);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
